// File: rtl/chi_sn_req_scheduler.sv
// rtl/chi_sn_req_scheduler.sv - round-robin CHI SN request scheduler with in-order owner tracking
//
// Shares one single-transaction, in-order CHI SN AHB bridge among NUM_REQ
// home-node request sources. Holds the bridge L-credit pool, records the
// owner of every forwarded request in an in-order FIFO and uses its head to
// route responses back and to pick the write-data source.
//
// Ports:
//   clk, arst_n                         clock, asynchronous active-low reset
//   req_valid/ready/opcode/addr/txn_id  per-requester request channel (packed)
//   wd_valid/ready/data                 per-requester write-data channel (packed)
//   sn_req_v/opcode/addr/txn_id         registered request flit to the bridge
//   sn_req_lcrd_v                       L-credit return from the bridge
//   sn_dat_v/sn_dat_data                registered write-data flit to the bridge
//   sn_rsp_v                            CompDBIDResp from the bridge
//   sn_rdat_v/sn_rdat_data              CompData from the bridge
//   rsp_v, rdat_v, rdat_data            routed response/read-data strobes, broadcast data
//   bad_op                              sticky illegal-opcode flag
//   credits                             current L-credit count
module chi_sn_req_scheduler #(
  parameter int         NUM_REQ   = 4,
  parameter int         MAX_OUTST = 1,
  parameter int         ADDR_W    = 48,
  parameter int         TXN_W     = 12,
  parameter int         DATA_W    = 512,
  parameter logic [6:0] OP_READ   = 7'h04,
  parameter logic [6:0] OP_WRITE  = 7'h1D
) (
  input  logic                               clk,
  input  logic                               arst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*7-1:0]               req_opcode,
  input  logic [NUM_REQ*ADDR_W-1:0]          req_addr,
  input  logic [NUM_REQ*TXN_W-1:0]           req_txn_id,
  input  logic [NUM_REQ-1:0]                 wd_valid,
  output logic [NUM_REQ-1:0]                 wd_ready,
  input  logic [NUM_REQ*DATA_W-1:0]          wd_data,
  output logic                               sn_req_v,
  output logic [6:0]                         sn_req_opcode,
  output logic [ADDR_W-1:0]                  sn_req_addr,
  output logic [TXN_W-1:0]                   sn_req_txn_id,
  input  logic                               sn_req_lcrd_v,
  output logic                               sn_dat_v,
  output logic [DATA_W-1:0]                  sn_dat_data,
  input  logic                               sn_rsp_v,
  input  logic                               sn_rdat_v,
  input  logic [DATA_W-1:0]                  sn_rdat_data,
  output logic [NUM_REQ-1:0]                 rsp_v,
  output logic [NUM_REQ-1:0]                 rdat_v,
  output logic [DATA_W-1:0]                  rdat_data,
  output logic                               bad_op,
  output logic [$clog2(MAX_OUTST+1)-1:0]     credits
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CRD_W = $clog2(MAX_OUTST+1);
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  // Storage is rounded up to a power of two so pointers index it at full width.
  localparam int DEPTH = 1 << PTR_W;

  typedef enum logic {W_IDLE, W_DATA} wstate_e;

  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [CRD_W-1:0]  credits_q, credits_d;
  logic [CRD_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
  logic [IDX_W-1:0]  own_idx_q [DEPTH];
  logic              own_wr_q  [DEPTH];
  wstate_e           wstate_q;
  logic              bad_op_q;
  logic              sn_req_v_q;
  logic [6:0]        sn_req_opcode_q;
  logic [ADDR_W-1:0] sn_req_addr_q;
  logic [TXN_W-1:0]  sn_req_txn_id_q;
  logic              sn_dat_v_q;
  logic [DATA_W-1:0] sn_dat_data_q;

  logic [NUM_REQ-1:0] legal, elig;
  logic               found, grant, can_grant;
  logic [IDX_W-1:0]   win;
  logic [6:0]         win_op;
  logic [IDX_W-1:0]   head_idx;
  logic               head_wr, fifo_empty, fifo_full;
  logic               rd_pop, rsp_hit, wd_acc, pop;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      legal[i] = (req_opcode[i*7 +: 7] == OP_READ) || (req_opcode[i*7 +: 7] == OP_WRITE);
    end
  end
  assign elig = req_valid & legal;

  // Round-robin search starting at rr_q; first eligible requester wins.
  always_comb begin : rr_search
    int j;
    j     = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && elig[j]) begin
        found = 1'b1;
        win   = IDX_W'(j);
      end
    end
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CRD_W'(MAX_OUTST));
  // Gated by arst_n so no ready leaks out while reset is held.
  assign can_grant  = arst_n && (credits_q != '0) && !fifo_full;
  assign grant      = can_grant && found;
  assign win_op     = req_opcode[int'(win)*7 +: 7];
  assign req_ready  = grant ? (NUM_REQ'(1) << win) : '0;
  assign rr_d       = (win == IDX_W'(NUM_REQ-1)) ? '0 : win + IDX_W'(1);

  assign head_idx = own_idx_q[rd_ptr_q];
  assign head_wr  = own_wr_q[rd_ptr_q];

  // Responses that do not match the head's type (or arrive with nothing
  // outstanding) are simply dropped.
  assign rd_pop  = sn_rdat_v && !fifo_empty && !head_wr;
  assign rsp_hit = sn_rsp_v && !fifo_empty && head_wr && (wstate_q == W_IDLE);
  assign wd_acc  = (wstate_q == W_DATA) && wd_valid[head_idx];
  assign pop     = rd_pop || wd_acc;

  assign rdat_v    = rd_pop  ? (NUM_REQ'(1) << head_idx) : '0;
  assign rsp_v     = rsp_hit ? (NUM_REQ'(1) << head_idx) : '0;
  assign wd_ready  = (wstate_q == W_DATA) ? ((NUM_REQ'(1) << head_idx) & wd_valid) : '0;
  assign rdat_data = sn_rdat_data;

  // A grant coinciding with a credit return cancels out; returns beyond the
  // initial pool are discarded.
  always_comb begin
    credits_d = credits_q;
    if (grant && !sn_req_lcrd_v) begin
      credits_d = credits_q - CRD_W'(1);
    end else if (!grant && sn_req_lcrd_v && (credits_q != CRD_W'(MAX_OUTST))) begin
      credits_d = credits_q + CRD_W'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    if (grant && !pop)      count_d = count_q + CRD_W'(1);
    else if (!grant && pop) count_d = count_q - CRD_W'(1);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rr_q            <= '0;
      credits_q       <= CRD_W'(MAX_OUTST);
      count_q         <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      bad_op_q        <= 1'b0;
      sn_req_v_q      <= 1'b0;
      sn_req_opcode_q <= '0;
      sn_req_addr_q   <= '0;
      sn_req_txn_id_q <= '0;
    end else begin
      credits_q  <= credits_d;
      count_q    <= count_d;
      bad_op_q   <= bad_op_q | (|(req_valid & ~legal));
      sn_req_v_q <= grant;
      if (grant) begin
        rr_q            <= rr_d;
        wr_ptr_q        <= (wr_ptr_q == PTR_W'(MAX_OUTST-1)) ? '0 : wr_ptr_q + PTR_W'(1);
        sn_req_opcode_q <= win_op;
        sn_req_addr_q   <= req_addr[int'(win)*ADDR_W +: ADDR_W];
        sn_req_txn_id_q <= req_txn_id[int'(win)*TXN_W +: TXN_W];
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTST-1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // Owner storage needs no reset: entries are only read while count_q says valid.
  always_ff @(posedge clk) begin
    if (grant) begin
      own_idx_q[wr_ptr_q] <= win;
      own_wr_q[wr_ptr_q]  <= (win_op == OP_WRITE);
    end
  end

  // Write FSM: waits for the bridge's CompDBIDResp, then forwards the head
  // owner's data beat.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wstate_q      <= W_IDLE;
      sn_dat_v_q    <= 1'b0;
      sn_dat_data_q <= '0;
    end else begin
      sn_dat_v_q <= 1'b0;
      case (wstate_q)
        W_IDLE: if (rsp_hit) wstate_q <= W_DATA;
        W_DATA: if (wd_acc) begin
          sn_dat_v_q    <= 1'b1;
          sn_dat_data_q <= wd_data[int'(head_idx)*DATA_W +: DATA_W];
          wstate_q      <= W_IDLE;
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  assign sn_req_v      = sn_req_v_q;
  assign sn_req_opcode = sn_req_opcode_q;
  assign sn_req_addr   = sn_req_addr_q;
  assign sn_req_txn_id = sn_req_txn_id_q;
  assign sn_dat_v      = sn_dat_v_q;
  assign sn_dat_data   = sn_dat_data_q;
  assign bad_op        = bad_op_q;
  assign credits       = credits_q;

endmodule

// File: tb/tb_chi_sn_req_scheduler.sv
// tb/tb_chi_sn_req_scheduler.sv - directed bench with queue-based reference model for chi_sn_req_scheduler
module tb_chi_sn_req_scheduler;

  localparam int N  = 4;
  localparam int AW = 48;
  localparam int TW = 12;
  localparam int DW = 512;
  localparam int MO = 2;
  localparam int CW = $clog2(MO+1);
  localparam logic [6:0] OPR = 7'h04;
  localparam logic [6:0] OPW = 7'h1D;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic [N-1:0]    req_valid, req_ready;
  logic [N*7-1:0]  req_opcode;
  logic [N*AW-1:0] req_addr;
  logic [N*TW-1:0] req_txn_id;
  logic [N-1:0]    wd_valid, wd_ready;
  logic [N*DW-1:0] wd_data;
  logic            sn_req_v;
  logic [6:0]      sn_req_opcode;
  logic [AW-1:0]   sn_req_addr;
  logic [TW-1:0]   sn_req_txn_id;
  logic            sn_req_lcrd_v;
  logic            sn_dat_v;
  logic [DW-1:0]   sn_dat_data;
  logic            sn_rsp_v, sn_rdat_v;
  logic [DW-1:0]   sn_rdat_data;
  logic [N-1:0]    rsp_v, rdat_v;
  logic [DW-1:0]   rdat_data;
  logic            bad_op;
  logic [CW-1:0]   credits;

  chi_sn_req_scheduler #(
    .NUM_REQ(N), .MAX_OUTST(MO), .ADDR_W(AW), .TXN_W(TW), .DATA_W(DW),
    .OP_READ(OPR), .OP_WRITE(OPW)
  ) u_dut (
    .clk(clk), .arst_n(arst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_addr(req_addr), .req_txn_id(req_txn_id),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .sn_req_v(sn_req_v), .sn_req_opcode(sn_req_opcode), .sn_req_addr(sn_req_addr),
    .sn_req_txn_id(sn_req_txn_id), .sn_req_lcrd_v(sn_req_lcrd_v),
    .sn_dat_v(sn_dat_v), .sn_dat_data(sn_dat_data),
    .sn_rsp_v(sn_rsp_v), .sn_rdat_v(sn_rdat_v), .sn_rdat_data(sn_rdat_data),
    .rsp_v(rsp_v), .rdat_v(rdat_v), .rdat_data(rdat_data),
    .bad_op(bad_op), .credits(credits)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: outstanding owners as a plain queue, credits as an int.
  typedef struct {int idx; bit w;} own_t;
  own_t          q[$];
  int            m_cred, m_rr, m_w;
  bit            m_bad, m_wdata, m_found, m_grant, m_pop, m_rsp;
  bit            m_req_v, m_dat_v;
  logic [6:0]    m_op;
  logic [AW-1:0] m_addr;
  logic [TW-1:0] m_txn;
  logic [DW-1:0] m_dat;
  logic [N-1:0]  e_rdy, e_rsp, e_rdat, e_wdr;
  own_t          m_h;

  function automatic bit is_legal(input logic [6:0] op);
    return (op == OPR) || (op == OPW);
  endfunction

  always @(negedge clk) begin
    if (!arst_n) begin
      m_cred = MO; m_rr = 0; m_bad = 0; m_wdata = 0; q.delete();
      m_req_v = 0; m_dat_v = 0;
      chk("rst_outputs", {req_ready, wd_ready, rsp_v, rdat_v, sn_req_v, sn_dat_v, bad_op}, '0);
      chk("rst_credits", credits, MO);
    end else begin
      chk("m_sn_req_v", sn_req_v, m_req_v);
      if (m_req_v) begin
        chk("m_sn_req_opcode", sn_req_opcode, m_op);
        chk("m_sn_req_addr", sn_req_addr, m_addr);
        chk("m_sn_req_txn_id", sn_req_txn_id, m_txn);
      end
      chk("m_sn_dat_v", sn_dat_v, m_dat_v);
      if (m_dat_v) chk("m_sn_dat_data", sn_dat_data, m_dat);
      chk("m_credits", credits, m_cred);
      chk("m_bad_op", bad_op, m_bad);

      m_found = 0; m_w = 0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (!m_found && req_valid[j] && is_legal(req_opcode[j*7 +: 7])) begin
          m_found = 1; m_w = j;
        end
      end
      m_grant = m_found && (m_cred > 0) && (q.size() < MO);
      e_rdy = '0; if (m_grant) e_rdy[m_w] = 1'b1;

      e_rsp = '0; e_rdat = '0; e_wdr = '0; m_pop = 0; m_rsp = 0;
      if (q.size() > 0) begin
        m_h = q[0];
        if (!m_h.w && sn_rdat_v) begin e_rdat[m_h.idx] = 1'b1; m_pop = 1; end
        if (m_h.w && !m_wdata && sn_rsp_v) begin e_rsp[m_h.idx] = 1'b1; m_rsp = 1; end
        if (m_wdata && wd_valid[m_h.idx]) begin e_wdr[m_h.idx] = 1'b1; m_pop = 1; end
      end
      chk("m_req_ready", req_ready, e_rdy);
      chk("m_rdat_v", rdat_v, e_rdat);
      chk("m_rsp_v", rsp_v, e_rsp);
      chk("m_wd_ready", wd_ready, e_wdr);
      if (e_rdat != 0) chk("m_rdat_data", rdat_data, sn_rdat_data);

      m_req_v = m_grant;
      if (m_grant) begin
        m_op   = req_opcode[m_w*7 +: 7];
        m_addr = req_addr[m_w*AW +: AW];
        m_txn  = req_txn_id[m_w*TW +: TW];
      end
      m_dat_v = 0;
      if (m_wdata && e_wdr != 0) begin
        m_dat_v = 1; m_dat = wd_data[m_h.idx*DW +: DW]; m_wdata = 0;
      end
      if (m_rsp) m_wdata = 1;
      if (m_pop) void'(q.pop_front());
      if (m_grant) q.push_back('{m_w, req_opcode[m_w*7 +: 7] == OPW});
      if (m_grant && !sn_req_lcrd_v) m_cred--;
      else if (!m_grant && sn_req_lcrd_v && m_cred < MO) m_cred++;
      if (m_grant) m_rr = (m_w + 1) % N;
      for (int i = 0; i < N; i++)
        if (req_valid[i] && !is_legal(req_opcode[i*7 +: 7])) m_bad = 1;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    req_valid = '0; wd_valid = '0; sn_req_lcrd_v = 0; sn_rsp_v = 0; sn_rdat_v = 0;
  endtask

  task automatic set_req(input int i, input logic [6:0] op, input logic [AW-1:0] a, input logic [TW-1:0] t);
    req_valid[i] = 1'b1;
    req_opcode[i*7 +: 7] = op;
    req_addr[i*AW +: AW] = a;
    req_txn_id[i*TW +: TW] = t;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  int winners[$];
  int exp_win[5] = '{1, 2, 3, 0, 1};

  initial begin
    clr();
    req_opcode = '0; req_addr = '0; req_txn_id = '0; wd_data = '0; sn_rdat_data = '0;
    repeat (3) cyc();
    #1 chk("reset_credits", credits, 2);
    chk("reset_ready", req_ready, 0);
    arst_n = 1'b1;

    // Single read from requester 0.
    cyc(); set_req(0, OPR, 48'h1000, 12'd5);
    #1 chk("t1_ready", req_ready, 4'b0001);
    cyc(); clr();
    #1 chk("t1_sn_req_v", sn_req_v, 1);
    chk("t1_addr", sn_req_addr, 48'h1000);
    chk("t1_txn", sn_req_txn_id, 5);
    chk("t1_credits", credits, 1);
    cyc(); sn_rdat_v = 1; sn_req_lcrd_v = 1; sn_rdat_data = {16{32'h1234_5678}};
    #1 chk("t1_rdat_v", rdat_v, 4'b0001);
    chk("t1_sn_req_v_pulse", sn_req_v, 0);
    cyc(); clr();
    #1 chk("t1_credits_back", credits, 2);

    // All four requesters read; bridge returns a credit every other cycle.
    for (int k = 0; k < 10; k++) begin
      cyc(); clr();
      for (int i = 0; i < N; i++) set_req(i, OPR, 48'h2000 + 48'(i*64), 12'(12'h100 + k));
      if (k % 2 == 1) begin
        sn_req_lcrd_v = 1; sn_rdat_v = 1; sn_rdat_data = {16{32'(k)}};
      end
      #1 if (req_ready != 0) winners.push_back($clog2(req_ready));
      if (k == 1) chk("t2_rdat_first", rdat_v, 4'b0010);
      if (k == 3) begin
        chk("t2_nogrant_k3", req_ready, 0);
        chk("t2_credits_zero", credits, 0);
      end
      if (k == 5) chk("t2_nogrant_k5", req_ready, 0);
    end
    chk("t2_num_grants", winners.size(), 6);
    for (int j = 0; j < 5; j++)
      if (j < winners.size()) chk($sformatf("t2_order_%0d", j), winners[j], exp_win[j]);
    for (int k = 0; k < 3; k++) begin
      cyc(); clr(); sn_req_lcrd_v = 1; sn_rdat_v = 1;
    end
    cyc(); clr();
    #1 chk("t2_credits_drained", credits, 2);

    // Write from requester 2.
    cyc(); set_req(2, OPW, 48'h3000, 12'd7);
    #1 chk("t3_ready", req_ready, 4'b0100);
    cyc(); clr();
    #1 chk("t3_opcode", sn_req_opcode, OPW);
    cyc(); sn_rsp_v = 1; sn_req_lcrd_v = 1;
    #1 chk("t3_rsp_v", rsp_v, 4'b0100);
    cyc(); clr(); wd_valid = 4'b0010; wd_data[1*DW +: DW] = {16{32'hDEAD_BEEF}};
    #1 chk("t3_wd_ready_other", wd_ready, 0);
    cyc(); wd_valid = 4'b0110; wd_data[2*DW +: DW] = {16{32'hA5A5_A5A5}};
    #1 chk("t3_wd_ready_owner", wd_ready, 4'b0100);
    cyc(); clr();
    #1 chk("t3_sn_dat_v", sn_dat_v, 1);
    chk("t3_sn_dat_data", sn_dat_data, {16{32'hA5A5_A5A5}});
    cyc(); sn_rdat_v = 1; sn_rsp_v = 1;
    #1 chk("t3_sn_dat_pulse", sn_dat_v, 0);
    chk("t3_empty_rdat_drop", rdat_v, 0);
    chk("t3_empty_rsp_drop", rsp_v, 0);

    // Illegal opcode on requester 1 alongside a legal read on 3.
    cyc(); clr(); set_req(1, 7'h01, 48'h4400, 12'd8); set_req(3, OPR, 48'h4000, 12'd9);
    #1 chk("t4_ready", req_ready, 4'b1000);
    chk("t4_bad_op_before", bad_op, 0);
    cyc(); req_valid[3] = 1'b0;
    #1 chk("t4_bad_op_set", bad_op, 1);
    chk("t4_illegal_stalled", req_ready, 0);
    cyc(); sn_rdat_v = 1; sn_req_lcrd_v = 1;
    #1 chk("t4_rdat_v", rdat_v, 4'b1000);
    chk("t4_illegal_still", req_ready, 0);
    cyc(); clr();
    #1 chk("t4_bad_op_sticky", bad_op, 1);

    // Credit corner cases.
    cyc(); set_req(0, OPR, 48'h5000, 12'd1);
    #1 chk("t5_ready0", req_ready, 4'b0001);
    cyc(); clr(); set_req(1, OPR, 48'h5040, 12'd2); sn_req_lcrd_v = 1;
    #1 chk("t5_ready1", req_ready, 4'b0010);
    chk("t5_credits_1", credits, 1);
    cyc(); clr(); sn_req_lcrd_v = 1;
    #1 chk("t5_grant_and_return", credits, 1);
    cyc(); sn_req_lcrd_v = 1;
    #1 chk("t5_credits_full", credits, 2);
    cyc(); clr();
    #1 chk("t5_no_overflow", credits, 2);
    cyc(); sn_rdat_v = 1;
    #1 chk("t5_rdat0", rdat_v, 4'b0001);
    cyc();
    #1 chk("t5_rdat1", rdat_v, 4'b0010);
    cyc(); clr();

    // Reset while waiting for write data.
    cyc(); set_req(0, OPW, 48'h6000, 12'd3);
    #1 chk("t6_ready", req_ready, 4'b0001);
    cyc(); clr();
    cyc(); sn_rsp_v = 1;
    #1 chk("t6_rsp_v", rsp_v, 4'b0001);
    cyc(); clr(); wd_valid = 4'b0001; wd_data[0 +: DW] = {16{32'hCAFE_F00D}};
    set_req(3, OPR, 48'h6100, 12'd4);
    #1 chk("t6_wd_ready_pre", wd_ready, 4'b0001);
    arst_n = 1'b0;
    #1 chk("t6_rst_wd_ready", wd_ready, 0);
    chk("t6_rst_req_ready", req_ready, 0);
    chk("t6_rst_credits", credits, 2);
    chk("t6_rst_valids", {sn_req_v, sn_dat_v, rsp_v, rdat_v}, 0);
    cyc(); clr();
    cyc(); arst_n = 1'b1;
    cyc(); set_req(3, OPR, 48'h7000, 12'd11);
    #1 chk("t6_post_ready", req_ready, 4'b1000);
    cyc(); clr();
    #1 chk("t6_post_sn_req_v", sn_req_v, 1);
    chk("t6_post_addr", sn_req_addr, 48'h7000);
    chk("t6_post_credits", credits, 1);
    cyc(); sn_rdat_v = 1; sn_req_lcrd_v = 1;
    #1 chk("t6_post_rdat", rdat_v, 4'b1000);
    cyc(); clr();
    repeat (2) cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/chi_sn_req_scheduler.md
Name: chi_sn_req_scheduler

Overview:
- Shares one CHI slave-node AHB bridge among NUM_REQ home-node request sources. The bridge is a single-transaction, in-order device.
- Arbitrates requests round-robin and holds the bridge's L-credit pool.
- Records request ownership in an in-order owner FIFO. Routes RSP/DAT flits back to the issuing requester and steers write data from the owner of the oldest write to the bridge.
- Sits between the HN request queues and the bridge's rx_req / rx_dat / tx_rsp / tx_dat ports.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_OUTST, 1, initial L-credits, equal to the owner FIFO depth (1..4)
ADDR_W, 48, request address width
TXN_W, 12, transaction ID width
DATA_W, 512, data flit payload width
OP_READ, 7'h04, ReadNoSnp opcode
OP_WRITE, 7'h1D, WriteNoSnpFull opcode

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_opcode  in  NUM_REQ*7  per-requester opcode
req_addr  in  NUM_REQ*ADDR_W  per-requester address
req_txn_id  in  NUM_REQ*TXN_W  per-requester transaction ID
wd_valid  in  NUM_REQ  per-requester write-data valid
wd_ready  out  NUM_REQ  write-data accept
wd_data  in  NUM_REQ*DATA_W  write data
sn_req_v  out  1  request flit valid to bridge
sn_req_opcode  out  7  forwarded opcode
sn_req_addr  out  ADDR_W  forwarded address
sn_req_txn_id  out  TXN_W  forwarded txn ID
sn_req_lcrd_v  in  1  credit return from bridge
sn_dat_v  out  1  write-data flit valid to bridge
sn_dat_data  out  DATA_W  write-data payload
sn_rsp_v  in  1  CompDBIDResp from bridge
sn_rdat_v  in  1  CompData from bridge
sn_rdat_data  in  DATA_W  read data
rsp_v  out  NUM_REQ  routed response strobe
rdat_v  out  NUM_REQ  routed read-data strobe
rdat_data  out  DATA_W  read data (broadcast)
bad_op  out  1  sticky illegal-opcode flag
credits  out  $clog2(MAX_OUTST+1)  current credit count

Behaviour:
Reset:
- credits=MAX_OUTST; owner FIFO empty; RR pointer=0; write FSM in W_IDLE; bad_op=0.
- All valid/ready outputs 0.
- Reset mid-transaction discards all state; the bridge is reset by the same arst_n.

Arbitration:
- Eligible means req_valid[i] and opcode is OP_READ or OP_WRITE.
- A grant requires credits>0 and owner FIFO not full.
- Round-robin starts at the RR pointer. After a grant, the pointer moves to winner+1 mod NUM_REQ.
- A grant asserts req_ready[winner] combinationally in the same cycle.
- The request is registered: sn_req_v pulses for exactly 1 cycle on the next cycle, carrying the winner's opcode, addr and txn_id.
- The owner {idx, is_write} is pushed to the FIFO in the grant cycle.
- At most one grant per cycle.

Illegal opcodes:
- A requester with valid and an illegal opcode is never granted; it stays stalled.
- bad_op sets the cycle after first detection and stays set until reset.

Credits:
- A grant decrements credits by 1. sn_req_lcrd_v increments by 1.
- On a simultaneous grant and credit return, credits stay unchanged.
- A credit return while credits==MAX_OUTST is ignored; no overflow.

Response routing (FIFO head = oldest owner):
- sn_rdat_v with a read head: rdat_v[head.idx]=1 in the same cycle; rdat_data=sn_rdat_data; pop head.
- sn_rsp_v with a write head: rsp_v[head.idx]=1 in the same cycle; write FSM W_IDLE->W_DATA.
- W_DATA: wd_ready[head.idx]=wd_valid[head.idx]. On acceptance, drive sn_dat_v=1 and sn_dat_data for 1 cycle (registered), pop head, go to W_IDLE.
- wd_ready is 0 for every requester except the head owner while in W_DATA.
- sn_rdat_v or sn_rsp_v with an empty FIFO, or a type mismatch against the head, is dropped. bad_op is not affected.
- When a push and a pop happen in the same cycle, both take effect.

Latency:
- Grant to sn_req_v: 1 cycle.
- Write data accept to sn_dat_v: 1 cycle.
- Bridge response to requester strobe: 0 cycles.

Test Plan:
- Reset, then req_valid=4'b0001 with OP_READ, addr 0x1000, txn 5 -> req_ready[0] in cycle 0. sn_req_v in cycle 1 with addr 0x1000, txn 5. credits 1->0.
- All 4 requesters issue reads back-to-back with MAX_OUTST=1 and the bridge returning a credit plus sn_rdat_v -> grants in order 0,1,2,3,0. rdat_v one-hot matches each owner. No grant while credits==0.
- Requester 2 issues a write -> sn_rsp_v gives rsp_v=4'b0100. wd_valid[2] with data 0xA5.. gives sn_dat_v 1 cycle later carrying 0xA5.., then FIFO empty. wd_valid[1] during W_DATA -> wd_ready[1]=0.
- Requester 1 uses opcode 7'h01 -> never granted; bad_op=1 from the next cycle. Requester 3's read is still served.
- MAX_OUTST=2, grant in the same cycle as sn_req_lcrd_v with credits=1 -> credits stays 1. A credit return at credits=2 leaves credits at 2.
- arst_n asserted in W_DATA -> all outputs 0 immediately. After release, credits=MAX_OUTST and a new read is granted normally.
